// File: rtl/regfile_port_arbiter_pkg.sv
// ============================================================================
// regfile_port_arbiter_pkg : shared constants and helpers for the RF arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_port_arbiter_pkg;

  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;
  localparam int REG_ZERO = 0;
  localparam int MAX_REQ  = 4;

  function automatic logic [1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin arbiter with owner lock; purely combinational
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_lock,
  input  logic               i_lock_held,
  input  logic [NUM_REQ-1:0] i_owner,
  input  logic [IW-1:0]      i_rr_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_rr_ptr_nxt
);

  logic w_locked;
  logic w_found;
  int   w_idx;

  // The lock only survives while the owner still asserts both req and lock.
  assign w_locked = i_lock_held & (|(i_owner & i_req & i_lock));

  always_comb begin
    o_gnt        = '0;
    o_rr_ptr_nxt = i_rr_ptr;
    w_found      = 1'b0;
    w_idx        = 0;
    if (w_locked) begin
      o_gnt = i_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
        if (!w_found && i_req[w_idx]) begin
          w_found        = 1'b1;
          o_gnt[w_idx]   = 1'b1;
          o_rr_ptr_nxt   = IW'((w_idx + 1) % NUM_REQ);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
// ============================================================================
// regfile_port_arbiter : shares one register-file port among NUM_REQ users
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    lock,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ*AW-1:0] ra1,
  input  logic [NUM_REQ*AW-1:0] ra2,
  input  logic [NUM_REQ*AW-1:0] wa,
  input  logic [NUM_REQ*DW-1:0] wd,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rsp_valid,
  output logic [NUM_REQ-1:0]    rsp_id,
  output logic [DW-1:0]         rsp_rd1,
  output logic [DW-1:0]         rsp_rd2,
  output logic [AW-1:0]         RF_ReadingReg1,
  output logic [AW-1:0]         RF_ReadingReg2,
  output logic [AW-1:0]         RF_WriteReg,
  output logic [DW-1:0]         RF_WriteData,
  output logic                  RF_WriteEnable,
  input  logic [DW-1:0]         RF_ReadingData1,
  input  logic [DW-1:0]         RF_ReadingData2
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0] r_owner;
  logic               r_lock_held;
  logic               r_rsp_valid;
  logic [NUM_REQ-1:0] r_rsp_id;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_rr_ptr_nxt;
  logic               w_any_gnt;
  int                 w_sel;
  logic [AW-1:0]      w_wa;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .i_req        (req),
    .i_lock       (lock),
    .i_lock_held  (r_lock_held),
    .i_owner      (r_owner),
    .i_rr_ptr     (r_rr_ptr),
    .o_gnt        (w_arb_gnt),
    .o_rr_ptr_nxt (w_rr_ptr_nxt)
  );

  // Grant is forced low during reset even though it is combinational.
  assign w_gnt     = w_arb_gnt & {NUM_REQ{RST_N}};
  assign w_any_gnt = |w_gnt;
  assign w_sel     = int'(onehot_to_idx(MAX_REQ'(w_gnt)));
  assign w_wa      = wa[w_sel*AW +: AW];

  assign gnt            = w_gnt;
  assign RF_ReadingReg1 = ra1[w_sel*AW +: AW];
  assign RF_ReadingReg2 = ra2[w_sel*AW +: AW];
  assign RF_WriteReg    = w_wa;
  assign RF_WriteData   = wd[w_sel*DW +: DW];
  assign RF_WriteEnable = w_any_gnt & we[w_sel] & (w_wa != AW'(REG_ZERO));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_lock_held <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_gnt;
      r_lock_held <= |(w_gnt & lock);
      r_rsp_valid <= w_any_gnt;
      r_rsp_id    <= w_gnt;
    end
  end

  // Read data arrives from the clocked register file in the response cycle.
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rd1   = RF_ReadingData1;
  assign rsp_rd2   = RF_ReadingData2;

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
// ============================================================================
// tb_regfile_port_arbiter : directed bench with a clocked register-file model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 5;
  localparam int DW      = 32;

  logic                  CLK;
  logic                  RST_N;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*AW-1:0] ra1;
  logic [NUM_REQ*AW-1:0] ra2;
  logic [NUM_REQ*AW-1:0] wa;
  logic [NUM_REQ*DW-1:0] wd;
  logic [NUM_REQ-1:0]    gnt;
  logic                  rsp_valid;
  logic [NUM_REQ-1:0]    rsp_id;
  logic [DW-1:0]         rsp_rd1;
  logic [DW-1:0]         rsp_rd2;
  logic [AW-1:0]         RF_ReadingReg1;
  logic [AW-1:0]         RF_ReadingReg2;
  logic [AW-1:0]         RF_WriteReg;
  logic [DW-1:0]         RF_WriteData;
  logic                  RF_WriteEnable;
  logic [DW-1:0]         RF_ReadingData1;
  logic [DW-1:0]         RF_ReadingData2;

  int n_assert = 0;
  int n_fail   = 0;

  logic          rf_load;
  logic [DW-1:0] rf [32];

  regfile_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .req             (req),
    .lock            (lock),
    .we              (we),
    .ra1             (ra1),
    .ra2             (ra2),
    .wa              (wa),
    .wd              (wd),
    .gnt             (gnt),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_rd1         (rsp_rd1),
    .rsp_rd2         (rsp_rd2),
    .RF_ReadingReg1  (RF_ReadingReg1),
    .RF_ReadingReg2  (RF_ReadingReg2),
    .RF_WriteReg     (RF_WriteReg),
    .RF_WriteData    (RF_WriteData),
    .RF_WriteEnable  (RF_WriteEnable),
    .RF_ReadingData1 (RF_ReadingData1),
    .RF_ReadingData2 (RF_ReadingData2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous register file: reads return the pre-write contents.
  always @(posedge CLK) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + i;
      rf[0] <= 32'hCAFE0000;
      rf[7] <= 32'h3;
    end else begin
      RF_ReadingData1 <= rf[RF_ReadingReg1];
      RF_ReadingData2 <= rf[RF_ReadingReg2];
      if (RF_WriteEnable) rf[RF_WriteReg] <= RF_WriteData;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_r(input int i, input logic w, input logic [AW-1:0] a_w,
                       input logic [DW-1:0] d, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    we[i]           = w;
    wa[i*AW +: AW]  = a_w;
    wd[i*DW +: DW]  = d;
    ra1[i*AW +: AW] = a1;
    ra2[i*AW +: AW] = a2;
  endtask

  task automatic step;
    @(negedge CLK);
  endtask

  initial begin
    RST_N   = 1'b0;
    rf_load = 1'b1;
    RF_ReadingData1 = '0;
    RF_ReadingData2 = '0;
    req  = '0;
    lock = '0;
    we   = '0;
    ra1  = '0;
    ra2  = '0;
    wa   = '0;
    wd   = '0;

    // Reset: outputs held low even with an active write request.
    step;
    req = 2'b01;
    set_r(0, 1'b1, 5'd5, 32'h11, 5'd0, 5'd0);
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_we", 64'(RF_WriteEnable), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_id", 64'(rsp_id), 64'h0);
    step;
    rf_load = 1'b0;
    RST_N   = 1'b1;

    // Round robin, no lock: 01,10,01,10
    req = 2'b11;
    set_r(0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd3);
    set_r(1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd4);
    #1;
    chk("rr0_gnt", 64'(gnt), 64'h1);
    chk("rr0_ra1", 64'(RF_ReadingReg1), 64'h1);
    step;
    chk("rr1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("rr1_rsp_id", 64'(rsp_id), 64'h1);
    chk("rr1_rd1", 64'(rsp_rd1), 64'h1001);
    chk("rr1_rd2", 64'(rsp_rd2), 64'h1003);
    #1;
    chk("rr1_gnt", 64'(gnt), 64'h2);
    step;
    chk("rr2_rsp_id", 64'(rsp_id), 64'h2);
    chk("rr2_rd1", 64'(rsp_rd1), 64'h1002);
    chk("rr2_rd2", 64'(rsp_rd2), 64'h1004);
    #1;
    chk("rr2_gnt", 64'(gnt), 64'h1);
    step;
    chk("rr3_rsp_id", 64'(rsp_id), 64'h1);
    #1;
    chk("rr3_gnt", 64'(gnt), 64'h2);

    // Write 0xDEADBEEF to r5, then read it back
    step;
    chk("rr4_rsp_id", 64'(rsp_id), 64'h2);
    chk("rr4_rd1", 64'(rsp_rd1), 64'h1002);
    req = 2'b01;
    set_r(0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    #1;
    chk("wr5_gnt", 64'(gnt), 64'h1);
    chk("wr5_we", 64'(RF_WriteEnable), 64'h1);
    chk("wr5_wreg", 64'(RF_WriteReg), 64'h5);
    chk("wr5_wdata", 64'(RF_WriteData), 64'hDEADBEEF);
    step;
    chk("wr5_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("wr5_rsp_id", 64'(rsp_id), 64'h1);
    chk("wr5_prewrite", 64'(rsp_rd1), 64'h1005);
    set_r(0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    chk("rd5_gnt", 64'(gnt), 64'h1);
    chk("rd5_we", 64'(RF_WriteEnable), 64'h0);

    // Lock by requester 1 starting from rr_ptr=1
    step;
    chk("rd5_rsp_id", 64'(rsp_id), 64'h1);
    chk("rd5_rd1", 64'(rsp_rd1), 64'hDEADBEEF);
    req  = 2'b11;
    lock = 2'b10;
    #1;
    chk("lk0_gnt", 64'(gnt), 64'h2);
    step;
    chk("lk1_rsp_id", 64'(rsp_id), 64'h2);
    #1;
    chk("lk1_gnt", 64'(gnt), 64'h2);
    step;
    chk("lk2_rsp_id", 64'(rsp_id), 64'h2);
    #1;
    chk("lk2_gnt", 64'(gnt), 64'h2);
    step;
    chk("lk3_rsp_id", 64'(rsp_id), 64'h2);
    lock = 2'b00;
    #1;
    chk("lk3_gnt", 64'(gnt), 64'h1);

    // Write to register 0 is granted but suppressed
    step;
    chk("lk4_rsp_id", 64'(rsp_id), 64'h1);
    req = 2'b01;
    set_r(0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
    #1;
    chk("wr0_gnt", 64'(gnt), 64'h1);
    chk("wr0_we", 64'(RF_WriteEnable), 64'h0);
    step;
    chk("wr0_rd1", 64'(rsp_rd1), 64'hCAFE0000);
    set_r(0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step;
    chk("rd0_rd1", 64'(rsp_rd1), 64'hCAFE0000);
    chk("rd0_rd2", 64'(rsp_rd2), 64'hCAFE0000);

    // Same-cycle read and write of r7 returns the old value
    set_r(0, 1'b1, 5'd7, 32'hA, 5'd7, 5'd0);
    #1;
    chk("rw7_we", 64'(RF_WriteEnable), 64'h1);
    step;
    chk("rw7_rd1", 64'(rsp_rd1), 64'h3);
    set_r(0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    step;
    chk("rd7_rd1", 64'(rsp_rd1), 64'hA);

    // Reset with a response pending, then arbitration restarts at requester 0
    step;
    chk("mr_rsp_valid_pre", 64'(rsp_valid), 64'h1);
    req = 2'b11;
    #1;
    chk("mr_gnt_pre", 64'(gnt), 64'h2);
    RST_N = 1'b0;
    #1;
    chk("mr_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mr_rsp_id", 64'(rsp_id), 64'h0);
    chk("mr_gnt", 64'(gnt), 64'h0);
    chk("mr_we", 64'(RF_WriteEnable), 64'h0);
    step;
    RST_N = 1'b1;
    #1;
    chk("mr_restart_gnt", 64'(gnt), 64'h1);
    step;
    chk("mr_restart_rsp", 64'(rsp_id), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single synchronous register-file access port (two read addresses, one write address/data/enable) between NUM_REQ requesters, e.g. pipeline writeback and a debug/loader unit.
- Round-robin arbitration with per-requester req/gnt handshake, optional lock for back-to-back grants, and enforcement of register 0 as read-only.
- Returns read data with a tagged response one cycle after grant, matching the register file's clocked-read latency.
- Sits directly between the requesters and the register file.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request, held until granted.
- lock  in  NUM_REQ  requester keeps ownership on the following cycle while its req stays high.
- we  in  NUM_REQ  per-requester write request.
- ra1  in  NUM_REQ*AW  read address 1, packed; requester i at [i*AW +: AW].
- ra2  in  NUM_REQ*AW  read address 2, packed.
- wa  in  NUM_REQ*AW  write address, packed.
- wd  in  NUM_REQ*DW  write data, packed.
- gnt  out  NUM_REQ  one-hot grant; combinational from the current request and state.
- rsp_valid  out  1  read data valid, one cycle after grant.
- rsp_id  out  NUM_REQ  one-hot owner of the current response.
- rsp_rd1  out  DW  read data 1; passes RF_ReadingData1 through.
- rsp_rd2  out  DW  read data 2; passes RF_ReadingData2 through.
- RF_ReadingReg1  out  AW  to register file A1.
- RF_ReadingReg2  out  AW  to register file A2.
- RF_WriteReg  out  AW  to register file A3.
- RF_WriteData  out  DW  to register file write data.
- RF_WriteEnable  out  1  to register file write enable.
- RF_ReadingData1  in  DW  from register file.
- RF_ReadingData2  in  DW  from register file.

Behaviour:
- Reset (async, RST_N=0):
  - rr_ptr=0; owner=none; lock_held=0.
  - rsp_valid=0; rsp_id=0.
  - Combinational outputs while in reset: gnt=0, RF_WriteEnable=0.
- Arbitration, every cycle:
  - If lock_held and the owner's req=1, the grant goes to the owner.
  - Otherwise the first req at or after rr_ptr, searching upward modulo NUM_REQ, is granted.
  - No req means gnt=0.
- Grant update:
  - On a non-lock grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - Locked grants do not advance rr_ptr.
- Lock: lock_held <= gnt[i] & lock[i]. A lock drops in the cycle its owner deasserts req or lock; arbitration that cycle is normal.
- Port mux: RF address and data outputs come from the granted requester. With no grant, the RF addresses still pass requester 0's addresses (harmless read), and RF_WriteEnable=0.
- RF_WriteEnable = granted & we[i] & (wa_i != 0). Writes to register 0 are silently dropped but still granted.
- Read latency: gnt in cycle N produces rsp_valid=1 with rsp_id=gnt(N) in cycle N+1. rsp_rd1/rsp_rd2 are the register-file outputs in cycle N+1.
- Same-cycle read and write of the same address by the granted requester returns the pre-write value. This is defined behaviour with no bypass.
- Read address 0 returns whatever the register file holds; the arbiter does not force zero.
- Back-to-back responses are allowed every cycle.
- Reset mid-transaction discards any pending response (rsp_valid=0 immediately).
- All inputs are sampled only when granted. Requester address and data must be stable in the grant cycle.

Decomposition:
- Shared package holds:
  - REG_ZERO address constant.
  - DW/AW defaults.
  - A one-hot-to-index function.
- Natural sub-module: rr_arbiter (NUM_REQ round-robin with lock; outputs gnt and next rr_ptr), reusable for memory-port sharing.
- Remaining logic is the port mux and response pipeline register.

Test Plan:
- Reset then single req[0] with we=1, wa=5, wd=32'hDEADBEEF:
  - gnt=01 and RF_WriteEnable=1 at that edge.
  - A later read with ra1=5 gives rsp_rd1=32'hDEADBEEF with rsp_valid=1 and rsp_id=01 one cycle after grant.
- req=11 held for 4 cycles, no lock -> gnt sequence 01,10,01,10; rsp_id follows one cycle later.
- req=11 with lock[1]=1 for 3 cycles, starting from rr_ptr=1:
  - gnt=10 on three consecutive cycles.
  - Dropping lock[1] -> next gnt=01.
- Write wa=0, wd=32'h1234 -> gnt asserted, RF_WriteEnable=0; a subsequent read of address 0 returns its prior value unchanged.
- Same-cycle we=1, wa=7, wd=32'hA, ra1=7 with reg7=32'h3 -> rsp_rd1=32'h3; the next read returns 32'hA.
- RST_N pulled low with rsp_valid pending -> rsp_valid=0, gnt=0 asynchronously. After release, arbitration restarts at requester 0.
